// File: rtl/vote_pkg.sv
// Shared constants, FSM state encoding and a popcount helper for the vote recorder.
package vote_pkg;

    localparam int NUM_CANDIDATES = 4;
    localparam int VOTE_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_LOCKOUT      = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_t;

    function automatic logic [2:0] count_ones(input logic [NUM_CANDIDATES-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/vote_recorder_button_debounce.sv
// Button conditioning: 2-FF synchronizer, consecutive-cycle debounce counter
// and a one-cycle pulse on each debounced rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            // Count only while the synchronized level disagrees; any agreement restarts it.
            if (r_sync[1] != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                    r_press <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/vote_recorder.sv
// Voting-mode front end: debounced buttons, one vote per press, saturating tallies.
// Optional total_votes output is enabled by defining VOTE_TOTAL_EN.
module vote_recorder
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LOCKOUT_CYCLES  = 100000000,
    parameter int VOTE_W          = VOTE_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode,
    input  logic              button1,
    input  logic              button2,
    input  logic              button3,
    input  logic              button4,
    output logic              valid_vote_casted,
    output logic [VOTE_W-1:0] candidate1_vote,
    output logic [VOTE_W-1:0] candidate2_vote,
    output logic [VOTE_W-1:0] candidate3_vote,
    output logic [VOTE_W-1:0] candidate4_vote,
    output logic              busy
`ifdef VOTE_TOTAL_EN
    ,
    output logic [VOTE_W+1:0] total_votes
`endif
);

    localparam int LCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCKOUT_CYCLES - 1);

    logic [NUM_CANDIDATES-1:0] w_btn;
    logic [NUM_CANDIDATES-1:0] w_level;
    logic [NUM_CANDIDATES-1:0] w_press;
    logic [NUM_CANDIDATES-1:0] w_sat;
    logic [2:0]                w_press_cnt;

    state_t            r_state;
    logic [LCK_W-1:0]  r_lock_cnt;
    logic              r_valid;
    logic [VOTE_W-1:0] r_tally [NUM_CANDIDATES];

    assign w_btn       = {button4, button3, button2, button1};
    assign w_press_cnt = count_ones(w_press);

    generate
        for (genvar gi = 0; gi < NUM_CANDIDATES; gi++) begin : g_cand
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clock),
                .rst     (reset),
                .i_btn   (w_btn[gi]),
                .o_level (w_level[gi]),
                .o_press (w_press[gi])
            );
            assign w_sat[gi] = &r_tally[gi];
        end
    endgenerate

`ifdef VOTE_TOTAL_EN
    logic              w_hit_sat;
    logic [VOTE_W+1:0] r_total;
    assign w_hit_sat   = |(w_press & w_sat);
    assign total_votes = r_total;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
            r_valid    <= 1'b0;
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
                r_tally[i] <= '0;
            end
`ifdef VOTE_TOTAL_EN
            r_total    <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!mode) begin
                        if (w_press_cnt == 3'd1) begin
                            // A press on a saturated tally still counts as a vote for acknowledgement.
                            for (int i = 0; i < NUM_CANDIDATES; i++) begin
                                if (w_press[i] && !w_sat[i]) begin
                                    r_tally[i] <= r_tally[i] + 1'b1;
                                end
                            end
`ifdef VOTE_TOTAL_EN
                            if (!w_hit_sat) begin
                                r_total <= r_total + 1'b1;
                            end
`endif
                            r_valid    <= 1'b1;
                            r_lock_cnt <= '0;
                            r_state    <= ST_LOCKOUT;
                        end else if (w_press_cnt > 3'd1) begin
                            r_state <= ST_WAIT_RELEASE;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (r_lock_cnt == LCK_LAST) begin
                        r_state <= ST_WAIT_RELEASE;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (w_level == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign valid_vote_casted = r_valid;
    assign busy              = (r_state != ST_IDLE);
    assign candidate1_vote   = r_tally[0];
    assign candidate2_vote   = r_tally[1];
    assign candidate3_vote   = r_tally[2];
    assign candidate4_vote   = r_tally[3];

endmodule

// File: tb/tb_vote_recorder.sv
// Directed bench for vote_recorder; a monitor checks each vote pulse against
// tally snapshots queued by the stimulus process.
module tb_vote_recorder;

    localparam int VW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          mode  = 1'b0;
    logic          button1 = 1'b0, button2 = 1'b0, button3 = 1'b0, button4 = 1'b0;
    logic          valid_vote_casted;
    logic [VW-1:0] candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote;
    logic          busy;
`ifdef VOTE_TOTAL_EN
    logic [VW+1:0] total_votes;
`endif

    always #5 clock = ~clock;

    vote_recorder #(
        .DEBOUNCE_CYCLES(4),
        .LOCKOUT_CYCLES (8),
        .VOTE_W         (VW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .mode             (mode),
        .button1          (button1),
        .button2          (button2),
        .button3          (button3),
        .button4          (button4),
        .valid_vote_casted(valid_vote_casted),
        .candidate1_vote  (candidate1_vote),
        .candidate2_vote  (candidate2_vote),
        .candidate3_vote  (candidate3_vote),
        .candidate4_vote  (candidate4_vote),
        .busy             (busy)
`ifdef VOTE_TOTAL_EN
        ,
        .total_votes      (total_votes)
`endif
    );

    int                n_vec = 0;
    int                n_bad = 0;
    int                pulse_cnt = 0;
    logic              prev_valid = 1'b0;
    logic [4*VW-1:0]   sb_q [$];
    int                exp_t [4];
    int                exp_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: every vote pulse must match the oldest queued tally snapshot.
    always @(negedge clock) begin
        logic [4*VW-1:0] snap;
        if (!reset && valid_vote_casted) begin
            pulse_cnt++;
            check("pulse_width", int'(prev_valid), 0);
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: got pulse expected none");
            end else begin
                snap = sb_q.pop_front();
                check("sb_c1", int'(candidate1_vote), int'(snap[VW-1:0]));
                check("sb_c2", int'(candidate2_vote), int'(snap[2*VW-1:VW]));
                check("sb_c3", int'(candidate3_vote), int'(snap[3*VW-1:2*VW]));
                check("sb_c4", int'(candidate4_vote), int'(snap[4*VW-1:3*VW]));
            end
        end
        prev_valid = valid_vote_casted;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] m);
        {button4, button3, button2, button1} = m;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            cycles(1);
            k++;
        end
        if (busy) check("idle_timeout", int'(busy), 0);
    endtask

    task automatic accept_vote(input int c);
        if (exp_t[c] < 255) begin
            exp_t[c]++;
            exp_total++;
        end
        sb_q.push_back({exp_t[3][VW-1:0], exp_t[2][VW-1:0], exp_t[1][VW-1:0], exp_t[0][VW-1:0]});
    endtask

    task automatic vote(input int c, input int hold);
        logic [3:0] m;
        accept_vote(c);
        m = 4'b0001 << c;
        set_btn(m);
        cycles(hold);
        set_btn(4'b0000);
        wait_idle();
        cycles(8);
    endtask

    task automatic check_tallies(input string tag);
        check({tag, "_c1"}, int'(candidate1_vote), exp_t[0]);
        check({tag, "_c2"}, int'(candidate2_vote), exp_t[1]);
        check({tag, "_c3"}, int'(candidate3_vote), exp_t[2]);
        check({tag, "_c4"}, int'(candidate4_vote), exp_t[3]);
    endtask

    initial begin
        int p0;
        int busy_cnt;
        int k;
        for (int i = 0; i < 4; i++) exp_t[i] = 0;

        cycles(3);
        reset = 1'b0;
        cycles(2);
        check("rst_valid", int'(valid_vote_casted), 0);
        check("rst_busy", int'(busy), 0);
        check_tallies("rst");

        // 1: single held press of button2
        p0 = pulse_cnt;
        busy_cnt = 0;
        accept_vote(1);
        set_btn(4'b0010);
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (busy) busy_cnt++;
        end
        set_btn(4'b0000);
        k = 0;
        while (busy && k < 300) begin
            cycles(1);
            busy_cnt++;
            k++;
        end
        check("t1_busy_ge9", int'(busy_cnt >= 9), 1);
        check("t1_pulses", pulse_cnt - p0, 1);
        cycles(8);
        check_tallies("t1");

        // 2: bouncing button1
        p0 = pulse_cnt;
        accept_vote(0);
        for (int i = 0; i < 5; i++) begin
            button1 = (i % 2 == 0);
            cycles(1);
        end
        check("t2_no_early", pulse_cnt - p0, 0);
        cycles(20);
        set_btn(4'b0000);
        wait_idle();
        cycles(8);
        check("t2_pulses", pulse_cnt - p0, 1);
        check_tallies("t2");

        // 3: simultaneous button3 + button4
        p0 = pulse_cnt;
        set_btn(4'b1100);
        cycles(15);
        check("t3_busy", int'(busy), 1);
        set_btn(4'b0100);
        cycles(12);
        check("t3_busy_held", int'(busy), 1);
        set_btn(4'b0000);
        wait_idle();
        cycles(8);
        check("t3_pulses", pulse_cnt - p0, 0);
        check_tallies("t3");

        // 4: result mode ignores presses
        p0 = pulse_cnt;
        mode = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_btn(4'b0001 << c);
            cycles(12);
            set_btn(4'b0000);
            cycles(10);
        end
        check("t4_busy", int'(busy), 0);
        check("t4_pulses", pulse_cnt - p0, 0);
        check_tallies("t4_m1");
        mode = 1'b0;
        cycles(2);
        vote(3, 12);
        check_tallies("t4_m0");

        // 5: saturation of candidate 1
        p0 = pulse_cnt;
        for (int i = 0; i < 260; i++) vote(0, 10);
        check("t5_pulses", pulse_cnt - p0, 260);
        check("t5_c1_sat", int'(candidate1_vote), 255);
        check_tallies("t5");
`ifdef VOTE_TOTAL_EN
        check("t5_total", int'(total_votes), exp_total);
`endif

        // 6: reset in the middle of lockout
        accept_vote(1);
        set_btn(4'b0010);
        k = 0;
        while (!valid_vote_casted && k < 100) begin
            cycles(1);
            k++;
        end
        check("t6_pulse_seen", int'(valid_vote_casted), 1);
        cycles(3);
        check("t6_busy_pre", int'(busy), 1);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) exp_t[i] = 0;
        exp_total = 0;
        check("t6_busy_rst", int'(busy), 0);
        check("t6_valid_rst", int'(valid_vote_casted), 0);
        check_tallies("t6_rst");
`ifdef VOTE_TOTAL_EN
        check("t6_total_rst", int'(total_votes), 0);
`endif
        set_btn(4'b0000);
        cycles(3);
        reset = 1'b0;
        cycles(10);
        check("t6_no_glitch", int'(valid_vote_casted), 0);
        vote(1, 12);
        check_tallies("t6_after");
`ifdef VOTE_TOTAL_EN
        check("t6_total", int'(total_votes), exp_total);
`endif

        cycles(5);
        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
